axi3_sram_slave: RTL and testbench
==================================

AXI3_SRAM_SLAVE -- requirements
Module: axi3_sram_slave

Interface
REQ-001 Parameter DATA_SIZE, default 32; AXI data width, 32 or 64 only.
REQ-002 Parameter ADDR_SIZE, default DATA_SIZE; AXI address width.
REQ-003 Parameter STRB_SIZE, default DATA_SIZE/8; byte-strobe width.
REQ-004 Parameter MEM_DEPTH, default 1024; SRAM depth in DATA_SIZE words.
REQ-005 Parameter MEM_AW, default $clog2(MEM_DEPTH); SRAM word-address width.
REQ-006 ACLK  in  1  sole clock, all state on rising edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  4/ADDR_SIZE/4/3/2  write address; AWVALID in 1; AWREADY out 1.
REQ-009 WID/WDATA/WSTRB/WLAST  in  4/DATA_SIZE/STRB_SIZE/1  write data; WVALID in 1; WREADY out 1.
REQ-010 BID/BRESP  out  4/2  write response; BVALID out 1; BREADY in 1.
REQ-011 ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  4/ADDR_SIZE/4/3/2  read address; ARVALID in 1; ARREADY out 1.
REQ-012 RID/RDATA/RRESP/RLAST  out  4/DATA_SIZE/2/1  read data; RVALID out 1; RREADY in 1.
REQ-013 mem_addr  out  MEM_AW  SRAM word address.
REQ-014 mem_we  out  1  SRAM write enable; mem_be  out  STRB_SIZE  byte enables; mem_d  out  DATA_SIZE  write data.
REQ-015 mem_q  in  DATA_SIZE  SRAM read data, valid exactly one cycle after mem_re.
REQ-016 mem_re  out  1  SRAM read enable.

Function
REQ-017 One transaction at a time; FSM states IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA.
REQ-018 IDLE: AWREADY/ARREADY asserted (combinationally from state and round-robin bit); both valid -> grant the channel not granted last; single valid -> grant it.
REQ-019 AW handshake: latch AWID/ADDR/LEN/SIZE/BURST, clear beat count and error flag, go WR_DATA; AR handshake: same for AR*, go RD_REQ.
REQ-020 WR_DATA: WREADY=1; each W handshake drives mem_we=1, mem_be=WSTRB, mem_d=WDATA, mem_addr=current beat address, same cycle.
REQ-021 WR_DATA exits to WR_RESP on handshake of beat number AWLEN (0-based), independent of WLAST.
REQ-022 WLAST=1 on a beat other than beat AWLEN, or WLAST=0 on beat AWLEN, sets the error flag.
REQ-023 WR_RESP: BVALID=1, BID=latched AWID, BRESP=SLVERR if error flag else OKAY; hold until BREADY, then IDLE.
REQ-024 RD_REQ: mem_re=1 at current beat address for one cycle, then RD_DATA.
REQ-025 RD_DATA: RVALID=1, RDATA=mem_q captured into a register in the cycle after mem_re, RID=latched ARID, RLAST=1 on beat ARLEN; outputs stable while RREADY=0.
REQ-026 R handshake: beat ARLEN -> IDLE; otherwise advance address -> RD_REQ (peak one beat per two cycles).
REQ-027 Next address: FIXED unchanged; INCR addr + 2^SIZE, aligned down to 2^SIZE; WRAP same, wrapping within a (LEN+1)*2^SIZE aligned boundary.
REQ-028 Address arithmetic is ADDR_SIZE bits and discards carry; mem_addr = address bits [MEM_AW+log2(STRB_SIZE)-1 : log2(STRB_SIZE)].
REQ-029 Error conditions set the flag for the whole burst: 2^SIZE > STRB_SIZE; WRAP with LEN not in {1,3,7,15}; BURST=2'b11; any beat address >= MEM_DEPTH*STRB_SIZE.
REQ-030 Errored write beat: mem_we=0. Errored read beat: mem_re=0, RDATA=0, RRESP=SLVERR; otherwise RRESP=OKAY.
REQ-031 AWREADY, ARREADY, WREADY are 0 outside IDLE/WR_DATA respectively; no request is dropped or reordered.

Reset
REQ-032 ARESET asserted, at any time including mid-burst: state IDLE, AWREADY=ARREADY=WREADY=BVALID=RVALID=RLAST=0, mem_we=mem_re=0, round-robin bit grants read first, beat counter 0.
REQ-033 Latched IDs, addresses and RDATA need no reset; an in-flight burst is abandoned without a response.

Structure
REQ-034 XRESP_OKAY=2'b00 and XRESP_SLVERR=2'b10 are added to axi3_pkg beside the existing XBURST_*/XSIZE_* constants; the FSM state enum stays local.
REQ-035 Beat address generation is one sub-module, axi3_slave_addr_gen (load, advance, error output), shared by both paths.

Verification
REQ-036 INCR write AWADDR=0x10, LEN=3, SIZE=2, WSTRB=4'hF, correct WLAST -> mem words 4..7 written, BRESP=OKAY, BID=AWID.
REQ-037 WRAP4 read ARADDR=0x38, SIZE=2 -> mem_addr sequence 14,15,12,13, RLAST on 4th beat, RRESP=OKAY.
REQ-038 Write with WLAST on beat 1 of LEN=3 -> all 4 beats accepted, BRESP=SLVERR.
REQ-039 Read ARADDR=MEM_DEPTH*4 -> RDATA=0, RRESP=SLVERR, mem_re never asserted.
REQ-040 AWVALID and ARVALID high together twice in succession -> grant read then write; RREADY held low 5 cycles -> RDATA/RLAST stable.
REQ-041 ARESET pulsed mid write burst -> all valids/readys 0 next edge; new write completes with OKAY.

Source files
------------

// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings for the slave blocks: burst types, beat sizes, response codes.
package axi3_pkg;

  localparam logic [1:0] XBURST_FIXED = 2'b00;
  localparam logic [1:0] XBURST_INCR  = 2'b01;
  localparam logic [1:0] XBURST_WRAP  = 2'b10;

  localparam logic [2:0] XSIZE_1   = 3'd0;
  localparam logic [2:0] XSIZE_2   = 3'd1;
  localparam logic [2:0] XSIZE_4   = 3'd2;
  localparam logic [2:0] XSIZE_8   = 3'd3;
  localparam logic [2:0] XSIZE_16  = 3'd4;
  localparam logic [2:0] XSIZE_32  = 3'd5;
  localparam logic [2:0] XSIZE_64  = 3'd6;
  localparam logic [2:0] XSIZE_128 = 3'd7;

  localparam logic [1:0] XRESP_OKAY   = 2'b00;
  localparam logic [1:0] XRESP_SLVERR = 2'b10;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi3_sram_slave_if.sv
// AXI3 five-channel bundle; the slave modport is the SRAM bridge side.
interface axi3_sram_slave_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = DATA_SIZE,
  parameter int unsigned STRB_SIZE = DATA_SIZE / 8
);
  logic [3:0]           AWID;
  logic [ADDR_SIZE-1:0] AWADDR;
  logic [3:0]           AWLEN;
  logic [2:0]           AWSIZE;
  logic [1:0]           AWBURST;
  logic                 AWVALID;
  logic                 AWREADY;

  logic [3:0]           WID;
  logic [DATA_SIZE-1:0] WDATA;
  logic [STRB_SIZE-1:0] WSTRB;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;

  logic [3:0]           BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;

  logic [3:0]           ARID;
  logic [ADDR_SIZE-1:0] ARADDR;
  logic [3:0]           ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;

  logic [3:0]           RID;
  logic [DATA_SIZE-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi3_slave_addr_gen.sv
// Beat address generator shared by the read and write paths, with a sticky per-burst error.
module axi3_slave_addr_gen
  import axi3_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned STRB_SIZE = 4,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                 clk_i,
  input  logic                 load_i,
  input  logic                 advance_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [3:0]           len_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 err_o
);
  localparam int unsigned SizeMax = $clog2(STRB_SIZE);
  localparam logic [ADDR_SIZE:0] MemBytes = (ADDR_SIZE + 1)'(MEM_DEPTH * STRB_SIZE);

  logic [ADDR_SIZE-1:0] addr_q, addr_d, next_addr;
  logic [ADDR_SIZE-1:0] bytes, aligned, incr, wrap_mask;
  logic [3:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic                 err_q, err_d, range_err, cfg_err;

  always_comb begin
    bytes     = ADDR_SIZE'(1) << size_q;
    aligned   = addr_q & ~(bytes - ADDR_SIZE'(1));
    incr      = aligned + bytes;
    wrap_mask = ((ADDR_SIZE'(len_q) + ADDR_SIZE'(1)) << size_q) - ADDR_SIZE'(1);
    case (burst_q)
      XBURST_FIXED: next_addr = addr_q;
      XBURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr & wrap_mask);
      default:      next_addr = incr;
    endcase
    range_err = {1'b0, addr_q} >= MemBytes;
    cfg_err   = (size_i > 3'(SizeMax)) || (burst_i == 2'b11) ||
                ((burst_i == XBURST_WRAP) && !wrap_len_ok(len_i));
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    if (load_i) begin
      addr_d  = addr_i;
      len_d   = len_i;
      size_d  = size_i;
      burst_d = burst_i;
      err_d   = cfg_err;
    end else if (advance_i) begin
      addr_d = next_addr;
      // An out-of-range beat poisons every later beat of the same burst.
      err_d  = err_q | range_err;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
    err_q   <= err_d;
  end

  assign addr_o = addr_q;
  assign err_o  = err_q | range_err;
endmodule

// File: rtl/axi3_sram_slave.sv
// AXI3 slave bridging one burst at a time onto a single-port SRAM with one-cycle read latency.
module axi3_sram_slave
  import axi3_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = DATA_SIZE,
  parameter int unsigned STRB_SIZE = DATA_SIZE / 8,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi3_sram_slave_if.slave     bus,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [STRB_SIZE-1:0] mem_be,
  output logic [DATA_SIZE-1:0] mem_d,
  input  logic [DATA_SIZE-1:0] mem_q,
  output logic                 mem_re
);
  localparam int unsigned Sb = $clog2(STRB_SIZE);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrData = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 pref_rd_q, pref_rd_d;
  logic                 rdy_en_q;
  logic [3:0]           beat_q, beat_d, len_q, len_d, id_q, id_d;
  logic                 burst_err_q, burst_err_d;
  logic                 first_q, first_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;

  logic                 idle, ar_hs, aw_hs, w_hs, r_hs, last_beat, ag_err;
  logic [ADDR_SIZE-1:0] ag_addr;
  logic                 unused_ok;

  assign idle        = (state_q == StIdle) && rdy_en_q;
  assign bus.ARREADY = idle && (pref_rd_q || !bus.AWVALID);
  assign bus.AWREADY = idle && (!pref_rd_q || !bus.ARVALID);
  assign ar_hs       = bus.ARVALID && bus.ARREADY;
  assign aw_hs       = bus.AWVALID && bus.AWREADY && !ar_hs;
  assign bus.WREADY  = (state_q == StWrData);
  assign w_hs        = bus.WVALID && bus.WREADY;
  assign r_hs        = bus.RVALID && bus.RREADY;
  assign last_beat   = (beat_q == len_q);

  axi3_slave_addr_gen #(
    .ADDR_SIZE (ADDR_SIZE),
    .STRB_SIZE (STRB_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_gen (
    .clk_i     (ACLK),
    .load_i    (ar_hs || aw_hs),
    .advance_i (w_hs || r_hs),
    .addr_i    (ar_hs ? bus.ARADDR : bus.AWADDR),
    .len_i     (ar_hs ? bus.ARLEN : bus.AWLEN),
    .size_i    (ar_hs ? bus.ARSIZE : bus.AWSIZE),
    .burst_i   (ar_hs ? bus.ARBURST : bus.AWBURST),
    .addr_o    (ag_addr),
    .err_o     (ag_err)
  );

  assign mem_addr = ag_addr[MEM_AW+Sb-1:Sb];
  assign mem_we   = w_hs && !ag_err;
  assign mem_be   = bus.WSTRB;
  assign mem_d    = bus.WDATA;
  assign mem_re   = (state_q == StRdReq) && !ag_err;

  assign bus.BVALID = (state_q == StWrResp);
  assign bus.BID    = id_q;
  assign bus.BRESP  = burst_err_q ? XRESP_SLVERR : XRESP_OKAY;

  // mem_q is only valid in the first RD_DATA cycle; later stall cycles replay the captured copy.
  assign bus.RVALID = (state_q == StRdData);
  assign bus.RID    = id_q;
  assign bus.RDATA  = ag_err ? '0 : (first_q ? mem_q : rdata_q);
  assign bus.RRESP  = ag_err ? XRESP_SLVERR : XRESP_OKAY;
  assign bus.RLAST  = bus.RVALID && last_beat;

  assign unused_ok = ^{bus.WID, ag_addr[ADDR_SIZE-1:MEM_AW+Sb], ag_addr[Sb-1:0]};

  always_comb begin
    state_d     = state_q;
    pref_rd_d   = pref_rd_q;
    beat_d      = beat_q;
    burst_err_d = burst_err_q;
    first_d     = 1'b0;
    id_d        = id_q;
    len_d       = len_q;
    rdata_d     = first_q ? mem_q : rdata_q;
    case (state_q)
      StIdle: begin
        if (ar_hs) begin
          state_d     = StRdReq;
          pref_rd_d   = 1'b0;
          beat_d      = 4'd0;
          burst_err_d = 1'b0;
          id_d        = bus.ARID;
          len_d       = bus.ARLEN;
        end else if (aw_hs) begin
          state_d     = StWrData;
          pref_rd_d   = 1'b1;
          beat_d      = 4'd0;
          burst_err_d = 1'b0;
          id_d        = bus.AWID;
          len_d       = bus.AWLEN;
        end
      end
      StWrData: begin
        if (w_hs) begin
          burst_err_d = burst_err_q | ag_err | (bus.WLAST != last_beat);
          if (last_beat) state_d = StWrResp;
          else           beat_d  = beat_q + 4'd1;
        end
      end
      StWrResp: begin
        if (bus.BREADY) state_d = StIdle;
      end
      StRdReq: begin
        state_d = StRdData;
        first_d = 1'b1;
      end
      StRdData: begin
        if (r_hs) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            state_d = StRdReq;
            beat_d  = beat_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= StIdle;
      pref_rd_q   <= 1'b1;
      rdy_en_q    <= 1'b0;
      beat_q      <= 4'd0;
      burst_err_q <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pref_rd_q   <= pref_rd_d;
      rdy_en_q    <= 1'b1;
      beat_q      <= beat_d;
      burst_err_q <= burst_err_d;
      first_q     <= first_d;
    end
  end

  always_ff @(posedge ACLK) begin
    id_q    <= id_d;
    len_q   <= len_d;
    rdata_q <= rdata_d;
  end
endmodule

// File: tb/tb_axi3_sram_slave.sv
// Directed bench for axi3_sram_slave with a behavioural one-cycle-latency SRAM.
module tb_axi3_sram_slave;
  import axi3_pkg::*;

  localparam int Lim = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi3_sram_slave_if bus ();

  logic [9:0]  mem_addr;
  logic        mem_we, mem_re;
  logic [3:0]  mem_be;
  logic [31:0] mem_d, mem_q;

  axi3_sram_slave dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_d    (mem_d),
    .mem_q    (mem_q),
    .mem_re   (mem_re)
  );

  logic [31:0] sram [1024];
  logic [9:0]  re_addrs [$];

  // mem_q carries garbage except in the cycle right after a read.
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_d[8*b +: 8];
    if (mem_re) begin
      mem_q <= sram[mem_addr];
      re_addrs.push_back(mem_addr);
    end else begin
      mem_q <= 32'hBAD0_BAD0;
    end
  end

  int total = 0;
  int bad = 0;

  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  logic [1:0]  bresp;
  logic [3:0]  bid;
  int          s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return 32'({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST,
                mem_we, mem_re});
  endfunction

  // All tasks start and end #1 after a rising edge.
  task automatic aw_go(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                       input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    bus.AWID = id; bus.AWADDR = a; bus.AWLEN = len; bus.AWSIZE = sz; bus.AWBURST = bt;
    bus.AWVALID = 1'b1;
    @(negedge clk);
    while (!bus.AWREADY && n < Lim) begin @(negedge clk); n++; end
    if (n >= Lim) chk("aw_timeout", 32'(bus.AWREADY), 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic ar_wait();
    int n = 0;
    @(negedge clk);
    while (!bus.ARREADY && n < Lim) begin @(negedge clk); n++; end
    if (n >= Lim) chk("ar_timeout", 32'(bus.ARREADY), 32'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic ar_set(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                        input logic [2:0] sz, input logic [1:0] bt);
    bus.ARID = id; bus.ARADDR = a; bus.ARLEN = len; bus.ARSIZE = sz; bus.ARBURST = bt;
    bus.ARVALID = 1'b1;
  endtask

  task automatic w_go(input int nbeats, input int last_at, input logic [31:0] base,
                      input logic [3:0] strb);
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      bus.WDATA = base + 32'(b); bus.WSTRB = strb; bus.WLAST = (b == last_at);
      bus.WVALID = 1'b1;
      @(negedge clk);
      while (!bus.WREADY && n < Lim) begin @(negedge clk); n++; end
      if (n >= Lim) chk("w_timeout", 32'(bus.WREADY), 32'd1);
      @(posedge clk); #1;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    bus.BREADY = 1'b1;
    @(negedge clk);
    while (!bus.BVALID && n < Lim) begin @(negedge clk); n++; end
    if (n >= Lim) chk("b_timeout", 32'(bus.BVALID), 32'd1);
    resp = bus.BRESP; id = bus.BID;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic r_get(input int nbeats);
    bus.RREADY = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      @(negedge clk);
      while (!bus.RVALID && n < Lim) begin @(negedge clk); n++; end
      if (n >= Lim) chk("r_timeout", 32'(bus.RVALID), 32'd1);
      rd_data[b] = bus.RDATA; rd_resp[b] = bus.RRESP; rd_last[b] = bus.RLAST;
      rd_id[b] = bus.RID;
      @(posedge clk); #1;
    end
    bus.RREADY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.AWVALID = 0; bus.AWID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0;
    bus.AWBURST = 0; bus.WVALID = 0; bus.WID = 0; bus.WDATA = 0; bus.WSTRB = 0;
    bus.WLAST = 0; bus.BREADY = 0; bus.ARVALID = 0; bus.ARID = 0; bus.ARADDR = 0;
    bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0; bus.RREADY = 0;

    // Reset state
    @(negedge clk);
    chk("reset_ctl", ctl_vec(), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_readys", 32'({bus.ARREADY, bus.AWREADY}), 32'b11);
    @(posedge clk); #1;

    // INCR write to words 4..7
    aw_go(4'h5, 32'h10, 4'd3, XSIZE_4, XBURST_INCR);
    w_go(4, 3, 32'h1111_0000, 4'hF);
    b_get(bresp, bid);
    chk("incr_bresp", 32'(bresp), 32'(XRESP_OKAY));
    chk("incr_bid", 32'(bid), 32'h5);
    for (int i = 0; i < 4; i++) chk("incr_mem", sram[4+i], 32'h1111_0000 + 32'(i));

    // Preload words 12..15, then WRAP4 read from 0x38
    aw_go(4'h1, 32'h30, 4'd3, XSIZE_4, XBURST_INCR);
    w_go(4, 3, 32'hC0DE_0000, 4'hF);
    b_get(bresp, bid);
    chk("pre_bresp", 32'(bresp), 32'(XRESP_OKAY));
    s = re_addrs.size();
    ar_set(4'h9, 32'h38, 4'd3, XSIZE_4, XBURST_WRAP);
    ar_wait();
    r_get(4);
    chk("wrap_a0", 32'(re_addrs[s]),   32'd14);
    chk("wrap_a1", 32'(re_addrs[s+1]), 32'd15);
    chk("wrap_a2", 32'(re_addrs[s+2]), 32'd12);
    chk("wrap_a3", 32'(re_addrs[s+3]), 32'd13);
    chk("wrap_d0", rd_data[0], 32'hC0DE_0002);
    chk("wrap_d1", rd_data[1], 32'hC0DE_0003);
    chk("wrap_d2", rd_data[2], 32'hC0DE_0000);
    chk("wrap_d3", rd_data[3], 32'hC0DE_0001);
    chk("wrap_last", 32'({rd_last[0], rd_last[1], rd_last[2], rd_last[3]}), 32'b0001);
    chk("wrap_resp", 32'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 32'd0);
    chk("wrap_rid", 32'(rd_id[3]), 32'h9);

    // Early WLAST on beat 1 of a 4-beat write
    aw_go(4'h2, 32'h40, 4'd3, XSIZE_4, XBURST_INCR);
    w_go(4, 1, 32'h4444_0000, 4'hF);
    b_get(bresp, bid);
    chk("wlast_bresp", 32'(bresp), 32'(XRESP_SLVERR));
    chk("wlast_bid", 32'(bid), 32'h2);

    // Read past the end of the SRAM
    s = re_addrs.size();
    ar_set(4'h3, 32'd4096, 4'd0, XSIZE_4, XBURST_INCR);
    ar_wait();
    r_get(1);
    chk("oob_rdata", rd_data[0], 32'd0);
    chk("oob_rresp", 32'(rd_resp[0]), 32'(XRESP_SLVERR));
    chk("oob_rlast", 32'(rd_last[0]), 32'd1);
    chk("oob_no_re", 32'(re_addrs.size()), 32'(s));

    // Oversized beat
    ar_set(4'h4, 32'h10, 4'd0, XSIZE_8, XBURST_INCR);
    ar_wait();
    r_get(1);
    chk("size_rresp", 32'(rd_resp[0]), 32'(XRESP_SLVERR));
    chk("size_rdata", rd_data[0], 32'd0);

    // FIXED read repeats word 5
    ar_set(4'h4, 32'h14, 4'd1, XSIZE_4, XBURST_FIXED);
    ar_wait();
    r_get(2);
    chk("fixed_d1", rd_data[1], 32'h1111_0001);
    chk("fixed_last", 32'({rd_last[0], rd_last[1]}), 32'b01);

    // Partial byte strobes on word 20
    aw_go(4'h0, 32'h50, 4'd0, XSIZE_4, XBURST_INCR);
    w_go(1, 0, 32'h1122_3344, 4'hF);
    b_get(bresp, bid);
    aw_go(4'h0, 32'h50, 4'd0, XSIZE_4, XBURST_INCR);
    w_go(1, 0, 32'hAABB_CCDD, 4'b0101);
    b_get(bresp, bid);
    chk("strb_mem", sram[20], 32'h11BB_33DD);

    // Simultaneous AW/AR twice: read first, then write; read held with RREADY low
    bus.AWID = 4'h6; bus.AWADDR = 32'h60; bus.AWLEN = 4'd0; bus.AWSIZE = XSIZE_4;
    bus.AWBURST = XBURST_INCR; bus.AWVALID = 1'b1;
    ar_set(4'h7, 32'h10, 4'd0, XSIZE_4, XBURST_INCR);
    @(negedge clk);
    chk("arb1_rdys", 32'({bus.ARREADY, bus.AWREADY}), 32'b10);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.RVALID && n < Lim) begin @(negedge clk); n++; end
      if (n >= Lim) chk("stall_timeout", 32'(bus.RVALID), 32'd1);
    end
    chk("stall_awrdy", 32'(bus.AWREADY), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rdata", bus.RDATA, 32'h1111_0000);
      chk("stall_rlast", 32'({bus.RVALID, bus.RLAST}), 32'b11);
      @(negedge clk);
    end
    @(posedge clk); #1; bus.RREADY = 1'b1;
    @(negedge clk);
    chk("stall_rid", 32'(bus.RID), 32'h7);
    @(posedge clk); #1; bus.RREADY = 1'b0;
    ar_set(4'h8, 32'h14, 4'd0, XSIZE_4, XBURST_INCR);
    @(negedge clk);
    chk("arb2_rdys", 32'({bus.ARREADY, bus.AWREADY}), 32'b01);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    w_go(1, 0, 32'h2424_2424, 4'hF);
    b_get(bresp, bid);
    chk("arb_bresp", 32'(bresp), 32'(XRESP_OKAY));
    chk("arb_bid", 32'(bid), 32'h6);
    chk("arb_mem", sram[24], 32'h2424_2424);
    ar_wait();
    r_get(1);
    chk("arb_rdata", rd_data[0], 32'h1111_0001);
    chk("arb_rid", 32'(rd_id[0]), 32'h8);

    // Reset mid write burst, then a fresh write
    aw_go(4'hA, 32'h80, 4'd3, XSIZE_4, XBURST_INCR);
    w_go(2, 15, 32'h7777_0000, 4'hF);
    @(negedge clk);
    chk("mid_wready", 32'(bus.WREADY), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_ctl", ctl_vec(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    aw_go(4'hB, 32'h90, 4'd0, XSIZE_4, XBURST_INCR);
    w_go(1, 0, 32'h5A5A_5A5A, 4'hF);
    b_get(bresp, bid);
    chk("post_bresp", 32'(bresp), 32'(XRESP_OKAY));
    chk("post_bid", 32'(bid), 32'hB);
    chk("post_mem", sram[36], 32'h5A5A_5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
